// File: rtl/ahb_sram_master_pkg.sv
// Package: ahb_sram_master_pkg
// Shared AHB-Lite codes, FSM state encoding and small address helpers used by
// the ahb_sram_master initiator and its address generator.
package ahb_sram_master_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_LAST = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // Size code 3 (doubleword) is not supported on this 32-bit bus; use word.
  function automatic logic [1:0] eff_size(input logic [1:0] s);
    return (s == 2'd3) ? 2'd2 : s;
  endfunction

  // Clear the address bits below the transfer size.
  function automatic logic [31:0] align_addr(input logic [31:0] a, input logic [1:0] s);
    logic [31:0] mask;
    mask = (32'd1 << s) - 32'd1;
    return a & ~mask;
  endfunction

endpackage

// File: rtl/ahb_sram_master_addr_gen.sv
// Module: ahb_sram_master_addr_gen
// Computes the address of the next beat to launch and whether that beat must
// be issued as NONSEQ (first beat, or first beat after a 2^BOUND_W boundary).
// Ports:
//   first_beat  in  1   next launch is the first beat of the command
//   start_addr  in  32  aligned start address of the command
//   cur_addr    in  32  address of the previously launched beat
//   size        in  2   effective transfer size (0..2)
//   next_addr   out 32  address for the beat about to launch
//   restart     out 1   beat must be NONSEQ
module ahb_sram_master_addr_gen #(
  parameter int BOUND_W = 10
) (
  input  logic        first_beat,
  input  logic [31:0] start_addr,
  input  logic [31:0] cur_addr,
  input  logic [1:0]  size,
  output logic [31:0] next_addr,
  output logic        restart
);

  always_comb begin
    // Plain 32-bit add: wraps modulo 2^32 by construction.
    next_addr = first_beat ? start_addr : (cur_addr + (32'd1 << size));
    restart   = first_beat || (next_addr[BOUND_W-1:0] == '0);
  end

endmodule

// File: rtl/ahb_sram_master.sv
// Module: ahb_sram_master
// AHB-Lite initiator turning {addr, len, size, dir} commands into SINGLE/INCR
// transfers with overlapped address/data phases. Handles wait states and the
// two-cycle ERROR response; read beats are returned on rd_valid/rd_data.
// Ports:
//   hclk, hreset                 clock, asynchronous active-high reset
//   cmd_valid/ready/write/addr/len/size   command handshake
//   wr_valid/wr_data/wr_ready    write beat stream (ready = consumed this cycle)
//   rd_valid/rd_data             read beat stream (one pulse per beat)
//   done, err                    command completion pulses
//   hsel..hwdata                 AHB-Lite master outputs
//   hready, hresp, hrdata        AHB-Lite slave responses
module ahb_sram_master
  import ahb_sram_master_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int BOUND_W = 10
) (
  input  logic             hclk,
  input  logic             hreset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [1:0]       cmd_size,
  input  logic             wr_valid,
  input  logic [31:0]      wr_data,
  output logic             wr_ready,
  output logic             rd_valid,
  output logic [31:0]      rd_data,
  output logic             done,
  output logic             err,
  output logic             hsel,
  output logic [31:0]      haddr,
  output logic [1:0]       htrans,
  output logic             hwrite,
  output logic [2:0]       hsize,
  output logic [2:0]       hburst,
  output logic [31:0]      hwdata,
  input  logic             hready,
  input  logic [1:0]       hresp,
  input  logic [31:0]      hrdata
);

  localparam int CNT_W = LEN_W + 1;

  state_t           state_q, state_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             write_q, write_d;
  logic [1:0]       size_q, size_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      start_q, start_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
  logic [31:0]      haddr_q, haddr_d;
  logic [1:0]       htrans_q, htrans_d;
  logic             hwrite_q, hwrite_d;
  logic [2:0]       hsize_q, hsize_d;
  logic [2:0]       hburst_q, hburst_d;
  logic [31:0]      hwdata_q, hwdata_d;
  logic [31:0]      wbuf_q, wbuf_d;
  logic             dphase_q, dphase_d;       // a data phase is in flight
  logic             dphase_wr_q, dphase_wr_d; // ...and it is a write
  logic             rd_valid_q, rd_valid_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] len_plus1;
  logic             issued_all;
  logic             launch;
  logic             hresp_ok;
  logic [31:0]      next_addr;
  logic             restart;
  logic [1:0]       cmd_size_eff;

  ahb_sram_master_addr_gen #(.BOUND_W(BOUND_W)) u_addr_gen (
    .first_beat (issue_cnt_q == '0),
    .start_addr (start_q),
    .cur_addr   (haddr_q),
    .size       (size_q),
    .next_addr  (next_addr),
    .restart    (restart)
  );

  assign len_plus1    = CNT_W'(len_q) + CNT_W'(1);
  assign issued_all   = (issue_cnt_q == len_plus1);
  assign hresp_ok     = (hresp == HRESP_OKAY);
  assign cmd_size_eff = eff_size(cmd_size);
  assign launch       = (state_q == ST_BUS) && hready && !issued_all && (!write_q || wr_valid);

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    len_d       = len_q;
    start_d     = start_q;
    issue_cnt_d = issue_cnt_q;
    done_cnt_d  = done_cnt_q;
    haddr_d     = haddr_q;
    htrans_d    = htrans_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hburst_d    = hburst_q;
    hwdata_d    = hwdata_q;
    wbuf_d      = wbuf_q;
    dphase_d    = dphase_q;
    dphase_wr_d = dphase_wr_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    // Pipeline advance on every hready edge: the pending address phase moves
    // into the data phase and the current data phase (if OKAY) is retired.
    if (hready) begin
      dphase_d    = htrans_q[1];
      dphase_wr_d = hwrite_q;
      if (htrans_q[1] && hwrite_q) begin
        hwdata_d = wbuf_q;
      end
      if (dphase_q && hresp_ok) begin
        done_cnt_d = done_cnt_q + CNT_W'(1);
        if (!dphase_wr_q) begin
          rd_valid_d = 1'b1;
          rd_data_d  = hrdata;
        end
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          write_d     = cmd_write;
          size_d      = cmd_size_eff;
          len_d       = cmd_len;
          start_d     = align_addr(cmd_addr, cmd_size_eff);
          issue_cnt_d = '0;
          done_cnt_d  = '0;
          hwrite_d    = cmd_write;
          hsize_d     = {1'b0, cmd_size_eff};
          hburst_d    = (cmd_len == '0) ? HBURST_SINGLE : HBURST_INCR;
          state_d     = ST_BUS;
        end
      end
      ST_BUS: begin
        if (dphase_q && !hresp_ok && !hready) begin
          // First ERROR cycle: cancel whatever address phase is pending.
          htrans_d = HTRANS_IDLE;
          state_d  = ST_ERR;
        end else if (hready) begin
          if (issued_all) begin
            // The final address phase is being accepted at this edge.
            htrans_d = HTRANS_IDLE;
            state_d  = ST_LAST;
          end else if (launch) begin
            haddr_d     = next_addr;
            htrans_d    = restart ? HTRANS_NONSEQ : HTRANS_SEQ;
            issue_cnt_d = issue_cnt_q + CNT_W'(1);
            if (write_q) begin
              wbuf_d = wr_data;
            end
          end else begin
            // Write data not available: haddr is left where it is.
            htrans_d = (issue_cnt_q == '0) ? HTRANS_IDLE : HTRANS_BUSY;
          end
        end
      end
      ST_LAST: begin
        if (dphase_q && !hresp_ok && !hready) begin
          htrans_d = HTRANS_IDLE;
          state_d  = ST_ERR;
        end else if (done_cnt_q == len_plus1) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (hready) begin
          dphase_d = 1'b0;
          done_d   = 1'b1;
          err_d    = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      write_q     <= 1'b0;
      size_q      <= '0;
      len_q       <= '0;
      start_q     <= '0;
      issue_cnt_q <= '0;
      done_cnt_q  <= '0;
      haddr_q     <= '0;
      htrans_q    <= HTRANS_IDLE;
      hwrite_q    <= 1'b0;
      hsize_q     <= '0;
      hburst_q    <= '0;
      hwdata_q    <= '0;
      wbuf_q      <= '0;
      dphase_q    <= 1'b0;
      dphase_wr_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      write_q     <= write_d;
      size_q      <= size_d;
      len_q       <= len_d;
      start_q     <= start_d;
      issue_cnt_q <= issue_cnt_d;
      done_cnt_q  <= done_cnt_d;
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hburst_q    <= hburst_d;
      hwdata_q    <= hwdata_d;
      wbuf_q      <= wbuf_d;
      dphase_q    <= dphase_d;
      dphase_wr_q <= dphase_wr_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign wr_ready  = launch && write_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign done      = done_q;
  assign err       = err_q;
  assign hsel      = 1'b1;
  assign haddr     = haddr_q;
  assign htrans    = htrans_q;
  assign hwrite    = hwrite_q;
  assign hsize     = hsize_q;
  assign hburst    = hburst_q;
  assign hwdata    = hwdata_q;

endmodule
